// File: rtl/i2c_eeprom_responder.sv
// I2C responder that emulates a 24LC256-class EEPROM on the Propeller boot pins.
// Define I2C_EEPROM_WRITE_EN to store bytes written over I2C; otherwise the array is a ROM.
module i2c_eeprom_responder #(
   parameter int         ADDR_BITS   = 15,
   parameter logic [6:0] DEV_ADDR    = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic                 scl_in,
   input  logic                 sda_in,
   output logic                 sda_oe,
   input  logic                 ld_we,
   input  logic [ADDR_BITS-1:0] ld_addr,
   input  logic [7:0]           ld_data,
   output logic                 busy
);

`ifdef I2C_EEPROM_WRITE_EN
   localparam logic WRITE_EN = 1'b1;
`else
   localparam logic WRITE_EN = 1'b0;
`endif

   localparam int                   DEPTH   = 1 << ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      IDLE, DEVADDR, ACK_DEV, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO,
      WRITE, ACK_WR, READ, MACK
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_h_q, sda_h_q;
   logic                   scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [6:0]             sh_q, sh_d;
   logic [7:0]             hi_q, hi_d;
   logic                   rw_q, rw_d;
   logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
   logic                   oe_q, oe_d;
   logic                   busy_q, busy_d;
   logic                   wr_s;
   logic [7:0]             rx_byte_s;
   logic [7:0]             rdata_q;
   logic [7:0]             mem_q [0:DEPTH-1];

   assign scl_s      = scl_sync_q[SYNC_STAGES-1];
   assign sda_s      = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise_s = scl_s & ~scl_h_q;
   assign scl_fall_s = ~scl_s & scl_h_q;
   assign start_s    = scl_s & scl_h_q & sda_h_q & ~sda_s;
   assign stop_s     = scl_s & scl_h_q & ~sda_h_q & sda_s;
   assign rx_byte_s  = {sh_q, sda_s};
   assign sda_oe     = oe_q;
   assign busy       = busy_q;

   // Line synchronizers plus one history stage; idle bus level is high.
   always_ff @(posedge clk) begin
      if (res) begin
         scl_sync_q <= {SYNC_STAGES{1'b1}};
         sda_sync_q <= {SYNC_STAGES{1'b1}};
         scl_h_q    <= 1'b1;
         sda_h_q    <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
         scl_h_q    <= scl_s;
         sda_h_q    <= sda_s;
      end
   end

   // Protocol state register.
   always_ff @(posedge clk) begin
      if (res) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         sh_q    <= 7'd0;
         hi_q    <= 8'd0;
         rw_q    <= 1'b0;
         ptr_q   <= {ADDR_BITS{1'b0}};
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         hi_q    <= hi_d;
         rw_q    <= rw_d;
         ptr_q   <= ptr_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic: bits sampled on SCL rise, SDA changed after SCL fall.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      hi_d    = hi_q;
      rw_d    = rw_q;
      ptr_d   = ptr_q;
      oe_d    = oe_q;
      busy_d  = busy_q;
      wr_s    = 1'b0;
      if (start_s) begin
         state_d = DEVADDR;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
      end else if (stop_s) begin
         state_d = IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (scl_rise_s) begin
         case (state_q)
            DEVADDR, ADDR_HI, ADDR_LO, WRITE: begin
               sh_d  = rx_byte_s[6:0];
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  cnt_d = 4'd0;
                  case (state_q)
                     DEVADDR: begin
                        if (rx_byte_s[7:1] == DEV_ADDR) begin
                           state_d = ACK_DEV;
                           busy_d  = 1'b1;
                           rw_d    = rx_byte_s[0];
                        end else begin
                           state_d = IDLE;
                           busy_d  = 1'b0;
                        end
                     end
                     ADDR_HI: begin
                        hi_d    = rx_byte_s;
                        state_d = ACK_HI;
                     end
                     ADDR_LO: begin
                        ptr_d   = ADDR_BITS'({hi_q, rx_byte_s});
                        state_d = ACK_LO;
                     end
                     default: begin
                        wr_s    = WRITE_EN;
                        ptr_d   = ptr_q + PTR_ONE;
                        state_d = ACK_WR;
                     end
                  endcase
               end else begin
                  state_d = state_q;
               end
            end
            READ: cnt_d = cnt_q + 4'd1;
            MACK: begin
               ptr_d = ptr_q + PTR_ONE;
               if (sda_s) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = READ;
                  cnt_d   = 4'd0;
               end
            end
            default: state_d = state_q;
         endcase
      end else if (scl_fall_s) begin
         // Ack states: first fall drives the ack, second fall ends the 9th clock.
         case (state_q)
            ACK_DEV: begin
               if (!oe_q) begin
                  oe_d = 1'b1;
               end else if (rw_q) begin
                  state_d = READ;
                  cnt_d   = 4'd0;
                  oe_d    = ~rdata_q[7];
               end else begin
                  state_d = ADDR_HI;
                  oe_d    = 1'b0;
               end
            end
            ACK_HI, ACK_LO, ACK_WR: begin
               if (!oe_q) begin
                  oe_d = 1'b1;
               end else begin
                  state_d = (state_q == ACK_HI) ? ADDR_LO : WRITE;
                  oe_d    = 1'b0;
               end
            end
            READ: begin
               if (cnt_q == 4'd8) begin
                  oe_d    = 1'b0;
                  state_d = MACK;
               end else begin
                  oe_d = ~rdata_q[3'd7 - cnt_q[2:0]];
               end
            end
            default: oe_d = oe_q;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Byte array: fabric load wins over an I2C write; 1-clk registered read of the pointer.
   always_ff @(posedge clk) begin
      if (ld_we) begin
         mem_q[ld_addr] <= ld_data;
      end else if (wr_s && !res) begin
         mem_q[ptr_q] <= rx_byte_s;
      end
      rdata_q <= mem_q[ptr_q];
   end

endmodule

// File: tb/tb_i2c_eeprom_responder.sv
// Bench for i2c_eeprom_responder: bit-banged I2C master against a byte-level EEPROM model.
module tb_i2c_eeprom_responder;
   localparam int AW    = 15;
   localparam int DEPTH = 1 << AW;
   localparam int Q     = 10;
   localparam logic [7:0] DEV_W = 8'hA0;
   localparam logic [7:0] DEV_R = 8'hA1;

   logic          clk = 1'b0;
   logic          res = 1'b1;
   logic          scl_m = 1'b1;
   logic          sda_m = 1'b1;
   logic          ld_we = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [7:0]    ld_data = 8'h00;
   logic          sda_oe, busy;
   logic          scl_in, sda_in;

   assign scl_in = scl_m;
   assign sda_in = sda_m & ~sda_oe;

   i2c_eeprom_responder #(.ADDR_BITS(AW), .DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk(clk), .res(res), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference state: byte array, address pointer, busy flag.
   logic [7:0] m_mem [0:DEPTH-1];
   int         m_ptr = 0;
   logic       m_busy = 1'b0;
   logic [7:0] rd_q[$];
   logic [7:0] wq[$];

   int vectors = 0;
   int miscompares = 0;
   logic  chk_en = 1'b0, chk_oe = 1'b0, chk_busy = 1'b0;
   string chk_name = "";
   int    p_seq = 0, ack_seq = 0;
   string p_name = "";
   logic [7:0] p_got = 8'h00, p_exp = 8'h00;

   // Single compare process: per-cycle window checks and posted value checks.
   always @(negedge clk) begin
      if (chk_en) begin
         vectors++;
         if (sda_oe !== chk_oe || busy !== chk_busy) begin
            miscompares++;
            $display("FAIL %s: got sda_oe=%b busy=%b, want sda_oe=%b busy=%b (t=%0t)",
                     chk_name, sda_oe, busy, chk_oe, chk_busy, $time);
         end
      end
      if (p_seq != ack_seq) begin
         ack_seq = p_seq;
         vectors++;
         if (p_got !== p_exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", p_name, p_got, p_exp, $time);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic post_check(input string nm, input logic [7:0] got, input logic [7:0] exp);
      p_name = nm;
      p_got  = got;
      p_exp  = exp;
      p_seq++;
      @(negedge clk);
      #1;
   endtask

   // One SCL clock, entered with SCL just driven low.
   task automatic slot(input logic m_sda, input logic e_oe, input logic e_busy,
                       input string nm, output logic smp);
      repeat (2) @(negedge clk);
      sda_m = m_sda;
      repeat (Q - 2) @(negedge clk);
      chk_oe = e_oe; chk_busy = e_busy; chk_name = nm; chk_en = 1'b1;
      repeat (Q) @(negedge clk);
      chk_en = 1'b0;
      scl_m  = 1'b1;
      repeat (Q) @(negedge clk);
      smp = sda_in;
      repeat (Q) @(negedge clk);
      scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      if (scl_m) begin
         sda_m = 1'b1;
         repeat (Q) @(negedge clk);
      end else begin
         repeat (2) @(negedge clk);
         sda_m = 1'b1;
         repeat (Q) @(negedge clk);
         scl_m = 1'b1;
         repeat (Q) @(negedge clk);
      end
      sda_m = 1'b0;
      repeat (Q) @(negedge clk);
      scl_m = 1'b0;
   endtask

   task automatic i2c_stop(input string nm);
      repeat (2) @(negedge clk);
      sda_m = 1'b0;
      repeat (Q - 2) @(negedge clk);
      chk_oe = 1'b0; chk_busy = m_busy; chk_name = nm; chk_en = 1'b1;
      repeat (Q) @(negedge clk);
      chk_en = 1'b0;
      scl_m  = 1'b1;
      repeat (Q) @(negedge clk);
      sda_m = 1'b1;
      repeat (Q) @(negedge clk);
      m_busy = 1'b0;
      post_check({nm, "_oe"}, {7'd0, sda_oe}, 8'h00);
      post_check({nm, "_busy"}, {7'd0, busy}, 8'h00);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic e_ack, input logic e_busy_bits,
                            input logic e_busy_ack, input string nm);
      logic smp;
      for (int i = 7; i >= 0; i--) slot(b[i], 1'b0, e_busy_bits, nm, smp);
      slot(1'b1, e_ack, e_busy_ack, {nm, "_ack"}, smp);
   endtask

   task automatic recv_byte(input logic [7:0] exp, input logic nack, input string nm);
      logic smp;
      logic [7:0] got;
      for (int i = 7; i >= 0; i--) begin
         slot(1'b1, ~exp[i], 1'b1, nm, smp);
         got[i] = smp;
      end
      rd_q.push_back(got);
      post_check({nm, "_data"}, got, exp);
      slot(nack, 1'b0, 1'b1, {nm, "_mack"}, smp);
   endtask

   task automatic set_addr(input logic [15:0] a);
      i2c_start();
      send_byte(DEV_W, 1'b1, m_busy, 1'b1, "dev_w");
      m_busy = 1'b1;
      send_byte(a[15:8], 1'b1, 1'b1, 1'b1, "addr_hi");
      send_byte(a[7:0], 1'b1, 1'b1, 1'b1, "addr_lo");
      m_ptr = int'(a) % DEPTH;
   endtask

   task automatic read_bytes(input int n);
      rd_q.delete();
      i2c_start();
      send_byte(DEV_R, 1'b1, m_busy, 1'b1, "dev_r");
      m_busy = 1'b1;
      for (int k = 0; k < n; k++) begin
         recv_byte(m_mem[m_ptr], (k == n - 1), "rd");
         m_ptr = (m_ptr + 1) % DEPTH;
      end
      m_busy = 1'b0;
      i2c_stop("rd_stop");
   endtask

   task automatic random_read(input logic [15:0] a, input int n);
      set_addr(a);
      read_bytes(n);
   endtask

   task automatic write_bytes(input logic [15:0] a);
      set_addr(a);
      foreach (wq[k]) begin
         send_byte(wq[k], 1'b1, 1'b1, 1'b1, "wr");
`ifdef I2C_EEPROM_WRITE_EN
         m_mem[m_ptr] = wq[k];
`endif
         m_ptr = (m_ptr + 1) % DEPTH;
      end
      i2c_stop("wr_stop");
   endtask

   initial begin
      int op, n;
      logic [15:0] ra;

      repeat (5) @(negedge clk);
      post_check("reset_oe", {7'd0, sda_oe}, 8'h00);
      post_check("reset_busy", {7'd0, busy}, 8'h00);
      res = 1'b0;

      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'($urandom);
      m_mem[0] = 8'hA5; m_mem[1] = 8'h3C; m_mem[2] = 8'h00; m_mem[3] = 8'hFF;
      m_mem[4] = 8'h69; m_mem[5] = 8'h96; m_mem[DEPTH-1] = 8'h5A;
      m_mem[16'h0100] = 8'hC3; m_mem[16'h0101] = 8'h7E;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         ld_we = 1'b1; ld_addr = AW'(i); ld_data = m_mem[i];
      end
      @(negedge clk);
      ld_we = 1'b0;
      repeat (4) @(negedge clk);

      random_read(16'h0000, 4);
      post_check("lit_rr_0", rd_q[0], 8'hA5);
      post_check("lit_rr_1", rd_q[1], 8'h3C);
      post_check("lit_rr_2", rd_q[2], 8'h00);
      post_check("lit_rr_3", rd_q[3], 8'hFF);

      i2c_start();
      send_byte(8'hA2, 1'b0, 1'b0, 1'b0, "bad_dev");
      send_byte(8'h00, 1'b0, 1'b0, 1'b0, "bad_dev_tail");
      i2c_stop("bad_stop");

      read_bytes(2);
      post_check("lit_cur_0", rd_q[0], 8'h69);
      post_check("lit_cur_1", rd_q[1], 8'h96);

      random_read(16'hFFFF, 2);
      post_check("lit_wrap_0", rd_q[0], 8'h5A);
      post_check("lit_wrap_1", rd_q[1], 8'hA5);

      wq.delete(); wq.push_back(8'h12); wq.push_back(8'h34);
      write_bytes(16'h0100);
      random_read(16'h0100, 2);
`ifdef I2C_EEPROM_WRITE_EN
      post_check("lit_wb_0", rd_q[0], 8'h12);
      post_check("lit_wb_1", rd_q[1], 8'h34);
`else
      post_check("lit_wb_0", rd_q[0], 8'hC3);
      post_check("lit_wb_1", rd_q[1], 8'h7E);
`endif

      set_addr(16'h0002);
      i2c_start();
      send_byte(DEV_R, 1'b1, 1'b1, 1'b1, "dev_r_rst");
      repeat (Q) @(negedge clk);
      post_check("rst_pre_oe", {7'd0, sda_oe}, 8'h01);
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      post_check("rst_oe", {7'd0, sda_oe}, 8'h00);
      post_check("rst_busy", {7'd0, busy}, 8'h00);
      m_busy = 1'b0;
      m_ptr  = 0;
      sda_m  = 1'b1;
      i2c_stop("rst_stop");
      read_bytes(1);
      post_check("lit_after_rst", rd_q[0], 8'hA5);

      for (int it = 0; it < 6; it++) begin
         op = $urandom_range(0, 2);
         ra = 16'($urandom);
         n  = $urandom_range(1, 3);
         case (op)
            0: random_read(ra, n);
            1: begin
               wq.delete();
               for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
               write_bytes(ra);
               read_bytes(1);
            end
            default: read_bytes(n);
         endcase
      end

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
